// File: rtl/bsg_source_sync_rx_token_return.sv
// Receive-side buffer for a source-synchronous channel. It buffers incoming words, returns
// credits as a decimated toggling token, and generates the 0-1-0 token-reset waveform.
module bsg_source_sync_rx_token_return #(
  parameter int unsigned channel_width_p                 = 8,
  parameter int unsigned lg_start_credits_p              = 5,
  parameter int unsigned lg_credit_to_token_decimation_p = 3,
  parameter int unsigned token_hold_cycles_p             = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [channel_width_p-1:0] data_i,
  output logic                       v_o,
  output logic [channel_width_p-1:0] data_o,
  input  logic                       yumi_i,
  output logic                       token_o,
  input  logic                       token_reset_req_i,
  output logic                       token_reset_busy_o,
  output logic                       overflow_o
);

  localparam int unsigned W     = channel_width_p;
  localparam int unsigned DEPTH = 1 << lg_start_credits_p;
  localparam int unsigned PTR_W = lg_start_credits_p + 1;
  localparam int unsigned CNT_W = lg_credit_to_token_decimation_p;
  localparam int unsigned PH_W  = (token_hold_cycles_p > 1) ? $clog2(token_hold_cycles_p) : 1;

  typedef enum logic [1:0] {RUN, RST_LO1, RST_HI, RST_LO2} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic               token_q, token_d;
  logic               v_q, v_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic [W-1:0]       mem_q [DEPTH];
  logic               run, full, enq, deq, ph_done;

  assign run     = (state_q == RUN);
  assign full    = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                   (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]);
  assign deq     = run && yumi_i && v_q;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign enq     = run && v_i && (!full || deq);
  assign ph_done = (ph_q == PH_W'(token_hold_cycles_p - 1));

  // Next-state: FIFO pointers, credit counter, token line and reset sequencer.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    token_d = token_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        if (enq) wr_d = wr_q + PTR_W'(1);
        if (deq) begin
          rd_d  = rd_q + PTR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '1) token_d = ~token_q;
        end
        if (v_i && full && !deq) ovf_d = 1'b1;
        if (token_reset_req_i) begin
          state_d = RST_LO1;
          wr_d    = wr_q;
          rd_d    = wr_q;
          cnt_d   = '0;
          ph_d    = '0;
          token_d = 1'b0;
        end
      end
      RST_LO1: begin
        ph_d = ph_q + PH_W'(1);
        if (ph_done) begin
          state_d = RST_HI;
          ph_d    = '0;
          token_d = 1'b1;
        end
      end
      RST_HI: begin
        ph_d = ph_q + PH_W'(1);
        if (ph_done) begin
          state_d = RST_LO2;
          ph_d    = '0;
          token_d = 1'b0;
        end
      end
      RST_LO2: begin
        ph_d = ph_q + PH_W'(1);
        if (ph_done) begin
          state_d = RUN;
          ph_d    = '0;
          token_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
    v_d    = (state_d == RUN) && (wr_d != rd_d);
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      token_q <= 1'b0;
      v_q     <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      token_q <= token_d;
      v_q     <= v_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Storage needs no reset; contents are only observed behind v_o.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_q[PTR_W-2:0]] <= data_i;
  end

  assign data_o             = mem_q[rd_q[PTR_W-2:0]];
  assign v_o                = v_q;
  assign token_o            = token_q;
  assign token_reset_busy_o = busy_q;
  assign overflow_o         = ovf_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i && yumi_i && !v_q && !busy_q)
      $error("bsg_source_sync_rx_token_return: yumi_i asserted while v_o=0");
  end
`endif

endmodule

// File: tb/tb_bsg_source_sync_rx_token_return.sv
// Bench for bsg_source_sync_rx_token_return: scoreboard model checked every cycle,
// a small vector table, and directed overflow / token-reset / async-reset sequences.
module tb_bsg_source_sync_rx_token_return;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DEC   = 8;
  localparam int unsigned HOLD  = 4;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       v_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       v_o;
  logic [7:0] data_o;
  logic       yumi_i = 1'b0;
  logic       token_o;
  logic       token_reset_req_i = 1'b0;
  logic       token_reset_busy_o;
  logic       overflow_o;

  always #5 clk_i = ~clk_i;

  bsg_source_sync_rx_token_return dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .v_i                (v_i),
    .data_i             (data_i),
    .v_o                (v_o),
    .data_o             (data_o),
    .yumi_i             (yumi_i),
    .token_o            (token_o),
    .token_reset_req_i  (token_reset_req_i),
    .token_reset_busy_o (token_reset_busy_o),
    .overflow_o         (overflow_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] sb[$];
  int         m_occ, m_cnt, m_busy;
  logic       m_tok, m_ovf;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       y;
    logic [7:0] exp_d;
    logic       exp_v;
    logic       exp_tok;
    logic       exp_ovf;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, " v_o"}, 32'(v_o), 32'(m_busy == 0 && m_occ > 0));
    check({tag, " token_o"}, 32'(token_o), 32'(m_tok));
    check({tag, " overflow_o"}, 32'(overflow_o), 32'(m_ovf));
    check({tag, " busy"}, 32'(token_reset_busy_o), 32'(m_busy > 0));
  endtask

  task automatic model_reset();
    sb.delete();
    m_occ  = 0;
    m_cnt  = 0;
    m_busy = 0;
    m_tok  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock: drive inputs, update model, compare head data before and outputs after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic y, input logic req,
                     input string tag);
    logic [7:0] exp_d;
    v_i = v;
    data_i = d;
    yumi_i = y;
    token_reset_req_i = req;
    if (m_busy > 0) begin
      m_busy--;
      m_tok = (m_busy >= HOLD + 1 && m_busy <= 2 * HOLD);
    end else begin
      if (y && m_occ > 0) begin
        exp_d = sb.pop_front();
        check({tag, " data_o"}, 32'(data_o), 32'(exp_d));
        m_occ--;
        m_cnt = (m_cnt + 1) % DEC;
        if (m_cnt == 0) m_tok = ~m_tok;
      end
      if (v) begin
        if (m_occ < DEPTH) begin
          sb.push_back(d);
          m_occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (req) begin
        sb.delete();
        m_occ  = 0;
        m_cnt  = 0;
        m_tok  = 1'b0;
        m_busy = 3 * HOLD;
      end
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    yumi_i = 1'b0;
    token_reset_req_i = 1'b0;
    check_outs(tag);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    v_i = 1'b0;
    yumi_i = 1'b0;
    token_reset_req_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_outs("reset");
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{v: 1'b0, d: 8'h00, y: 1'b0, exp_d: 8'h00, exp_v: 1'b0, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};
    vecs[1] = '{v: 1'b1, d: 8'hA5, y: 1'b0, exp_d: 8'h00, exp_v: 1'b1, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};
    vecs[2] = '{v: 1'b1, d: 8'h3C, y: 1'b0, exp_d: 8'h00, exp_v: 1'b1, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{v: 1'b0, d: 8'h00, y: 1'b1, exp_d: 8'hA5, exp_v: 1'b1, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};
    vecs[4] = '{v: 1'b0, d: 8'h00, y: 1'b1, exp_d: 8'h3C, exp_v: 1'b0, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};
    vecs[5] = '{v: 1'b0, d: 8'h00, y: 1'b0, exp_d: 8'h00, exp_v: 1'b0, exp_tok: 1'b0, exp_ovf: 1'b0, exp_busy: 1'b0};

    // Reset values and idle hold
    model_reset();
    #3;
    check("async reset v_o", 32'(v_o), 32'(0));
    check("async reset token_o", 32'(token_o), 32'(0));
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    // Vector table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].y) check("vec data_o", 32'(data_o), 32'(vecs[i].exp_d));
      cyc(vecs[i].v, vecs[i].d, vecs[i].y, 1'b0, "vec");
      check("vec v_o", 32'(v_o), 32'(vecs[i].exp_v));
      check("vec token_o", 32'(token_o), 32'(vecs[i].exp_tok));
      check("vec overflow_o", 32'(overflow_o), 32'(vecs[i].exp_ovf));
      check("vec busy", 32'(token_reset_busy_o), 32'(vecs[i].exp_busy));
    end

    // Streaming 0x00..0x0F with a yumi every cycle the head is valid
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'(m_occ > 0), 1'b0, "stream");
    for (int i = 0; i < 40 && m_occ > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "stream drain");
    check("stream drained", 32'(m_occ), 32'(0));
    check("stream token back low", 32'(token_o), 32'(0));

    // Overflow: 33rd word dropped without yumi
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "fill");
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, "ovf drop");
    check("ovf sticky set", 32'(overflow_o), 32'(1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, "ovf hold");
    for (int i = 0; i < 40 && m_occ > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "ovf drain");

    // Full with simultaneous yumi: word accepted, no overflow
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "fill2");
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, "full enq+deq");
    check("full enq+deq no ovf", 32'(overflow_o), 32'(0));
    for (int i = 0; i < 40 && m_occ > 0; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "fill2 drain");

    // Token reset with credit counter at 5 and 3 words buffered; inputs driven while busy
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "pre");
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "pre yumi");
    check("pre occupancy", 32'(m_occ), 32'(3));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "treq");
    for (int i = 0; i < 3 * HOLD; i++) begin
      check("busy token shape", 32'(token_o), 32'(i >= HOLD && i < 2 * HOLD));
      cyc(1'b1, 8'hC3, 1'b1, 1'b1, "busy");
    end
    check("after reset v_o", 32'(v_o), 32'(0));
    check("after reset busy", 32'(token_reset_busy_o), 32'(0));
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "post");
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, "post yumi");
    check("post 7 yumis token", 32'(token_o), 32'(0));
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "post yumi8");
    check("post 8 yumis token", 32'(token_o), 32'(1));

    // Async reset in the RST_HI phase
    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, "treq2");
    for (int i = 0; i < HOLD; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, "to hi");
    check("in RST_HI token", 32'(token_o), 32'(1));
    #2;
    reset_n_i = 1'b0;
    #1;
    check("abort token_o", 32'(token_o), 32'(0));
    check("abort busy", 32'(token_reset_busy_o), 32'(0));
    check("abort v_o", 32'(v_o), 32'(0));
    check("abort overflow_o", 32'(overflow_o), 32'(0));
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0, 1'b0, "post abort");
    cyc(1'b0, 8'h00, 1'b1, 1'b0, "post abort yumi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
